cpri_prb_comb_rx: RTL and testbench

Receive-side counterpart of the CPRI PRB combined test-data generator.
- Consumes the 8-lane, 64-bit CPRI PRB stream and its per-chip sop strobe.
- Acquires and tracks chip alignment through a HUNT/VERIFY/LOCK state machine.
- Re-emits aligned data tagged with word and chip indices.
- Produces a per-frame XOR checksum and an error count, used by the self-test path to check link integrity.

---
 rtl/cpri_prb_comb_rx.sv | 196 +++++++++++++++++++
 tb/tb_cpri_prb_comb_rx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpri_prb_comb_rx.sv
// CPRI PRB combined receiver: acquires chip alignment (HUNT/VERIFY/LOCK), re-emits
// aligned words with word/chip indices, and produces a per-frame XOR checksum.
module cpri_prb_comb_rx #(
  parameter int unsigned DAT_DW      = 64,
  parameter int unsigned CHIP_LEN    = 96,
  parameter int unsigned FRAME_CHIPS = 462,
  parameter int unsigned LOCK_CNT    = 3,
  parameter int unsigned LOSS_CNT    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sop_cpri_i,
  input  logic [DAT_DW-1:0]   dat_cpri0_i,
  input  logic [DAT_DW-1:0]   dat_cpri1_i,
  input  logic [DAT_DW-1:0]   dat_cpri2_i,
  input  logic [DAT_DW-1:0]   dat_cpri3_i,
  input  logic [DAT_DW-1:0]   dat_cpri4_i,
  input  logic [DAT_DW-1:0]   dat_cpri5_i,
  input  logic [DAT_DW-1:0]   dat_cpri6_i,
  input  logic [DAT_DW-1:0]   dat_cpri7_i,
  output logic                lock_o,
  output logic                vld_o,
  output logic [6:0]          word_idx_o,
  output logic [8:0]          chip_idx_o,
  output logic [8*DAT_DW-1:0] dat_o,
  output logic                frame_end_o,
  output logic [DAT_DW-1:0]   chksum_o,
  output logic [15:0]         err_cnt_o,
  output logic                lost_lock_o
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCK = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [6:0]          word_q, word_d, word_nxt;
  logic [8:0]          chip_q, chip_d, chip_cur, chip_sel;
  logic [MW-1:0]       match_q, match_d;
  logic [BW-1:0]       bad_q, bad_d;
  logic [DAT_DW-1:0]   acc_q, acc_d, lanes_x;
  logic [8*DAT_DW-1:0] lanes_cat;
  logic                lock_q, lock_d, vld_q, vld_d, fe_q, fe_d, lost_q, lost_d;
  logic [6:0]          widx_q, widx_d;
  logic [8:0]          cidx_q, cidx_d;
  logic [8*DAT_DW-1:0] dat_q, dat_d;
  logic [DAT_DW-1:0]   chk_q, chk_d;
  logic [15:0]         err_q, err_d;
  logic                at_w0, err_ev, enter, emit;

  always_comb begin
    lanes_cat = {dat_cpri7_i, dat_cpri6_i, dat_cpri5_i, dat_cpri4_i,
                 dat_cpri3_i, dat_cpri2_i, dat_cpri1_i, dat_cpri0_i};
    lanes_x   = dat_cpri0_i ^ dat_cpri1_i ^ dat_cpri2_i ^ dat_cpri3_i ^
                dat_cpri4_i ^ dat_cpri5_i ^ dat_cpri6_i ^ dat_cpri7_i;
    at_w0     = (word_q == '0);
    word_nxt  = (word_q == 7'(CHIP_LEN - 1)) ? '0 : word_q + 7'd1;
    // chip_q holds the chip of the previous locked word; it advances on word 0
    chip_cur  = at_w0 ? ((chip_q == 9'(FRAME_CHIPS - 1)) ? '0 : chip_q + 9'd1) : chip_q;
    err_ev    = (sop_cpri_i != at_w0);

    state_d = state_q;
    word_d  = word_q;
    chip_d  = chip_q;
    match_d = match_q;
    bad_d   = bad_q;
    acc_d   = acc_q;
    vld_d   = 1'b0;
    widx_d  = widx_q;
    cidx_d  = cidx_q;
    dat_d   = dat_q;
    fe_d    = 1'b0;
    chk_d   = chk_q;
    err_d   = err_q;
    lost_d  = 1'b0;
    enter   = 1'b0;
    emit    = 1'b0;

    case (state_q)
      HUNT: begin
        word_d = '0;
        if (sop_cpri_i) begin
          match_d = MW'(1);
          word_d  = 7'(1 % CHIP_LEN);
          if (LOCK_CNT == 1) enter = 1'b1;
          else               state_d = VERIFY;
        end
      end
      VERIFY: begin
        word_d = word_nxt;
        if (at_w0 && sop_cpri_i) begin
          match_d = match_q + MW'(1);
          if (match_q + MW'(1) == MW'(LOCK_CNT)) enter = 1'b1;
        end else if (at_w0) begin
          state_d = HUNT;
          word_d  = '0;
          match_d = '0;
        end else if (sop_cpri_i) begin
          word_d  = 7'(1 % CHIP_LEN);
          match_d = MW'(1);
        end
      end
      LOCK: begin
        word_d = word_nxt;
        if (err_ev) begin
          if (err_q != '1) err_d = err_q + 16'd1;
          bad_d = bad_q + BW'(1);
          if (bad_q + BW'(1) == BW'(LOSS_CNT)) begin
            state_d = HUNT;
            word_d  = '0;
            match_d = '0;
            bad_d   = '0;
            acc_d   = '0;
            lost_d  = 1'b1;
          end else begin
            emit = 1'b1;
          end
        end else begin
          if (sop_cpri_i) bad_d = '0;
          emit = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase

    if (enter) begin
      state_d = LOCK;
      bad_d   = '0;
    end

    // word_q is already 0 on the lock-entry word, so one emit path covers both cases
    chip_sel = enter ? '0 : chip_cur;
    if (enter || emit) begin
      vld_d  = 1'b1;
      dat_d  = lanes_cat;
      widx_d = word_q;
      cidx_d = chip_sel;
      chip_d = chip_sel;
      acc_d  = (chip_sel == '0 && at_w0) ? lanes_x : (acc_q ^ lanes_x);
      if (chip_sel == 9'(FRAME_CHIPS - 1) && word_q == 7'(CHIP_LEN - 1)) begin
        fe_d  = 1'b1;
        chk_d = acc_q ^ lanes_x;
      end
    end

    lock_d = (state_d == LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      word_q  <= '0;
      chip_q  <= '0;
      match_q <= '0;
      bad_q   <= '0;
      acc_q   <= '0;
      lock_q  <= 1'b0;
      vld_q   <= 1'b0;
      widx_q  <= '0;
      cidx_q  <= '0;
      dat_q   <= '0;
      fe_q    <= 1'b0;
      chk_q   <= '0;
      err_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      chip_q  <= chip_d;
      match_q <= match_d;
      bad_q   <= bad_d;
      acc_q   <= acc_d;
      lock_q  <= lock_d;
      vld_q   <= vld_d;
      widx_q  <= widx_d;
      cidx_q  <= cidx_d;
      dat_q   <= dat_d;
      fe_q    <= fe_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  assign lock_o      = lock_q;
  assign vld_o       = vld_q;
  assign word_idx_o  = widx_q;
  assign chip_idx_o  = cidx_q;
  assign dat_o       = dat_q;
  assign frame_end_o = fe_q;
  assign chksum_o    = chk_q;
  assign err_cnt_o   = err_q;
  assign lost_lock_o = lost_q;

endmodule

// File: tb/tb_cpri_prb_comb_rx.sv
// Randomized bench for cpri_prb_comb_rx; a cycle-time based reference model predicts
// every output, with a shortened frame to keep runs short.
module tb_cpri_prb_comb_rx;

  localparam int unsigned DW  = 64;
  localparam int unsigned CL  = 96;
  localparam int unsigned FC  = 16;
  localparam int unsigned LKC = 3;
  localparam int unsigned LSC = 2;
  localparam int unsigned FL  = CL * FC;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            sop = 1'b0;
  logic [8*DW-1:0] din = '0;
  logic            lock_o, vld_o, frame_end_o, lost_lock_o;
  logic [6:0]      word_idx_o;
  logic [8:0]      chip_idx_o;
  logic [8*DW-1:0] dat_o;
  logic [DW-1:0]   chksum_o;
  logic [15:0]     err_cnt_o;

  cpri_prb_comb_rx #(.DAT_DW(DW), .CHIP_LEN(CL), .FRAME_CHIPS(FC), .LOCK_CNT(LKC), .LOSS_CNT(LSC)) dut (
    .clk(clk), .rst_n(rst_n), .sop_cpri_i(sop),
    .dat_cpri0_i(din[0*DW +: DW]), .dat_cpri1_i(din[1*DW +: DW]),
    .dat_cpri2_i(din[2*DW +: DW]), .dat_cpri3_i(din[3*DW +: DW]),
    .dat_cpri4_i(din[4*DW +: DW]), .dat_cpri5_i(din[5*DW +: DW]),
    .dat_cpri6_i(din[6*DW +: DW]), .dat_cpri7_i(din[7*DW +: DW]),
    .lock_o(lock_o), .vld_o(vld_o), .word_idx_o(word_idx_o), .chip_idx_o(chip_idx_o),
    .dat_o(dat_o), .frame_end_o(frame_end_o), .chksum_o(chksum_o),
    .err_cnt_o(err_cnt_o), .lost_lock_o(lost_lock_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: alignment tracked as an origin cycle t0, outputs derived from
  // elapsed cycles since lock entry.
  int              m_mode;  // 0 hunt, 1 verify, 2 lock
  int              t, t0, m_match, m_bad, lock_t;
  logic [DW-1:0]   facc;
  logic            e_lock, e_vld, e_fe, e_lost;
  logic [6:0]      e_w;
  logic [8:0]      e_c;
  logic [8*DW-1:0] e_dat;
  logic [DW-1:0]   e_chk;
  logic [15:0]     e_err;

  task automatic model_reset();
    m_mode = 0; t = 0; t0 = 0; m_match = 0; m_bad = 0; lock_t = 0; facc = '0;
    e_lock = 0; e_vld = 0; e_fe = 0; e_lost = 0; e_w = '0; e_c = '0;
    e_dat = '0; e_chk = '0; e_err = '0;
  endtask

  task automatic model_step(input logic s, input logic [8*DW-1:0] d);
    logic [DW-1:0] x;
    int pos, n;
    logic out;
    x = '0;
    for (int i = 0; i < 8; i++) x ^= d[i*DW +: DW];
    pos = (t - t0) % CL;
    out = 0; e_vld = 0; e_fe = 0; e_lost = 0;
    case (m_mode)
      0: if (s) begin
        t0 = t; m_match = 1;
        if (LKC == 1) begin m_mode = 2; lock_t = t; m_bad = 0; out = 1; end
        else m_mode = 1;
      end
      1: if (pos == 0) begin
        if (s) begin
          m_match++;
          if (m_match == LKC) begin m_mode = 2; lock_t = t; m_bad = 0; out = 1; end
        end else m_mode = 0;
      end else if (s) begin
        t0 = t; m_match = 1;
      end
      default: begin
        if (s != (pos == 0)) begin
          if (e_err != 16'hFFFF) e_err++;
          m_bad++;
          if (m_bad == LSC) begin m_mode = 0; m_bad = 0; e_lost = 1; end
          else out = 1;
        end else begin
          if (s) m_bad = 0;
          out = 1;
        end
      end
    endcase
    if (out) begin
      n = t - lock_t;
      e_vld = 1; e_dat = d;
      e_w = 7'(n % CL);
      e_c = 9'((n / CL) % FC);
      if (n % FL == 0) facc = x; else facc ^= x;
      if (n % FL == FL - 1) begin e_fe = 1; e_chk = facc; end
    end
    e_lock = (m_mode == 2);
    t++;
  endtask

  function automatic logic [611:0] dut_vec();
    return {lock_o, vld_o, word_idx_o, chip_idx_o, dat_o, frame_end_o, chksum_o, err_cnt_o, lost_lock_o};
  endfunction

  function automatic logic [611:0] exp_vec();
    return {e_lock, e_vld, e_w, e_c, e_dat, e_fe, e_chk, e_err, e_lost};
  endfunction

  function automatic logic [8*DW-1:0] rand_lanes();
    logic [8*DW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic cyc(input logic s, input logic [8*DW-1:0] d);
    sop = s; din = d;
    model_step(s, d);
    @(posedge clk); #1;
    if (n_fail > 40) finish_run();
  endtask

  task automatic do_reset();
    sop = 0; din = '0; rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    model_reset();
    #1;
    n_chk++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_async got=%h exp=%h", dut_vec(), exp_vec());
    end
    @(posedge clk); #1;
    n_chk++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL reset_hold got=%h exp=0", dut_vec());
    end
    rst_n = 1;
  endtask

  task automatic test_lock_acquire();
    do_reset();
    for (int k = 0; k < 192 + 96 * 4; k++) begin
      cyc(k % 96 == 0, '0);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL acquire k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (k == 191) begin
        n_chk++;
        if (lock_o !== 1'b0) begin n_fail++; $display("FAIL acquire_early lock=%b exp=0", lock_o); end
      end
      if (k == 192 || k == 192 + 96) begin
        n_chk++;
        if ({lock_o, vld_o, word_idx_o, chip_idx_o} !== {1'b1, 1'b1, 7'd0, 9'((k - 192) / 96)}) begin
          n_fail++;
          $display("FAIL acquire_first k=%0d got lock=%b vld=%b w=%0d c=%0d", k, lock_o, vld_o, word_idx_o, chip_idx_o);
        end
      end
    end
  endtask

  task automatic test_checksum();
    int nv, fe_cnt;
    logic [8*DW-1:0] d;
    nv = 0; fe_cnt = 0;
    do_reset();
    for (int k = 0; k < 192 + 2 * FL + 4; k++) begin
      d = '0;
      if (k - 192 == 5 * 96 + 10) d[3*DW +: DW] = 64'hA5;
      cyc(k % 96 == 0, d);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL checksum k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (vld_o === 1'b1) nv++;
      if (frame_end_o === 1'b1) begin
        fe_cnt++;
        n_chk++;
        if ({nv, chksum_o} !== {fe_cnt * int'(FL), (fe_cnt == 1) ? 64'hA5 : 64'h0}) begin
          n_fail++; $display("FAIL frame_end n=%0d vlds=%0d chk=%h", fe_cnt, nv, chksum_o);
        end
      end
    end
    n_chk++;
    if (fe_cnt != 2) begin n_fail++; $display("FAIL frame_end_count got=%0d exp=2", fe_cnt); end
  endtask

  task automatic test_single_miss();
    logic s;
    do_reset();
    for (int k = 0; k < 192 + 96 * 10; k++) begin
      s = (k % 96 == 0) && (k != 192 + 96 * 3) && (k != 192 + 96 * 6);
      cyc(s, rand_lanes());
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL single_miss k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    n_chk++;
    if ({lock_o, vld_o, err_cnt_o} !== {1'b1, 1'b1, 16'd2}) begin
      n_fail++; $display("FAIL single_miss_end lock=%b vld=%b err=%0d exp 1 1 2", lock_o, vld_o, err_cnt_o);
    end
  endtask

  task automatic test_loss(input int extra);
    logic s;
    int lost_cnt;
    lost_cnt = 0;
    do_reset();
    for (int k = 0; k < 900; k++) begin
      if (extra != 0) s = ((k % 96 == 0) && k != 576) || (k == 480 + 40);
      else            s = (k % 96 == 0) && k != 480 && k != 576;
      cyc(s, rand_lanes());
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL loss%0d k=%0d got=%h exp=%h", extra, k, dut_vec(), exp_vec());
      end
      if (lost_lock_o === 1'b1) lost_cnt++;
      if (k == 576) begin
        n_chk++;
        if ({lost_lock_o, lock_o, vld_o, err_cnt_o} !== {1'b1, 1'b0, 1'b0, 16'd2}) begin
          n_fail++;
          $display("FAIL loss_event lost=%b lock=%b vld=%b err=%0d exp 1 0 0 2", lost_lock_o, lock_o, vld_o, err_cnt_o);
        end
      end
      if (k == 863 || k == 864) begin
        n_chk++;
        if (lock_o !== (k == 864)) begin n_fail++; $display("FAIL relock k=%0d lock=%b", k, lock_o); end
      end
    end
    n_chk++;
    if (lost_cnt != 1) begin n_fail++; $display("FAIL lost_pulses got=%0d exp=1", lost_cnt); end
  endtask

  task automatic test_realign();
    logic s;
    do_reset();
    for (int k = 0; k < 440; k++) begin
      s = (k < 146) ? (k % 96 == 0) : ((k - 146) % 96 == 0);
      cyc(s, rand_lanes());
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL realign k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (k == 242 || k == 337 || k == 338) begin
        n_chk++;
        if (lock_o !== (k == 338)) begin n_fail++; $display("FAIL realign_lock k=%0d lock=%b", k, lock_o); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int ev;
    ev = 0;
    do_reset();
    for (int k = 0; k < 700; k++) cyc(k % 96 == 0, rand_lanes());
    n_chk++;
    if (lock_o !== 1'b1) begin n_fail++; $display("FAIL midframe_prelock lock=%b exp=1", lock_o); end
    rst_n = 0;
    model_reset();
    #1;
    n_chk++;
    if (dut_vec() !== '0) begin n_fail++; $display("FAIL midframe_reset got=%h exp=0", dut_vec()); end
    rst_n = 1;
    for (int k = 0; k < 400; k++) begin
      cyc(k % 96 == 0, rand_lanes());
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL midframe k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (frame_end_o === 1'b1 || lost_lock_o === 1'b1) ev++;
    end
    n_chk++;
    if (ev != 0) begin n_fail++; $display("FAIL midframe_events got=%0d exp=0", ev); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_acquire();
    test_checksum();
    test_single_miss();
    test_loss(0);
    test_loss(1);
    test_realign();
    test_reset_midframe();
    finish_run();
  end

endmodule
